// File: rtl/reg_read_stage_pkg.sv
// Shared scheduler types for the register-read stage: tag, operand and payload widths.
// Build option: REG_READ_BYPASS_EN enables the writeback bypass in operand resolution.
package reg_read_stage_pkg;

    localparam int SCHED_PREG_NUM  = 64;
    localparam int SCHED_TAG_W     = $clog2(SCHED_PREG_NUM);
    localparam int SCHED_DATA_W    = 32;
    localparam int SCHED_PAYLOAD_W = 64;

    typedef logic [SCHED_TAG_W-1:0]     tag_t;
    typedef logic [SCHED_DATA_W-1:0]    data_t;
    // Opaque uop payload: option code, rob_idx, position_bit, imm, pdest.
    typedef logic [SCHED_PAYLOAD_W-1:0] payload_t;

endpackage

// File: rtl/reg_read_skid_buf.sv
// Per-lane 2-entry (main + skid) buffer whose ready output comes straight from a register.
// Handshake: a transfer happens on a rising edge where valid & ready are both high.
module reg_read_skid_buf
    import reg_read_stage_pkg::*;
#(
    parameter int W = SCHED_DATA_W
) (
    input  logic         clk,
    input  logic         a_rst_n,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         main_v_q, main_v_d;
    logic         skid_v_q, skid_v_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept;
    logic         consume;

    // Ready depends only on skid occupancy, so no path exists from out_ready_i.
    assign in_ready_o  = ~skid_v_q;
    assign accept      = in_valid_i & ~skid_v_q;
    assign consume     = main_v_q & out_ready_i;
    assign out_valid_o = main_v_q;
    assign out_data_o  = main_q;

    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d   = main_q;
        skid_d   = skid_q;
        if (consume) begin
            main_v_d = skid_v_q;
            skid_v_d = 1'b0;
            if (skid_v_q) begin
                main_d = skid_q;
            end
        end
        // Accept only happens with skid empty, so it never races the skid->main move.
        if (accept) begin
            if (!main_v_q || consume) begin
                main_d   = in_data_i;
                main_v_d = 1'b1;
            end else begin
                skid_d   = in_data_i;
                skid_v_d = 1'b1;
            end
        end
        if (flush_i) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

endmodule

// File: rtl/reg_read_stage.sv
// Register-read stage: resolves two operands per uop at issue and buffers them per lane.
// Build option: define REG_READ_BYPASS_EN to forward matching writeback data over the PRF.
module reg_read_stage
    import reg_read_stage_pkg::*;
#(
    parameter  int LANE_NUM  = 2,
    parameter  int PREG_NUM  = SCHED_PREG_NUM,
    parameter  int DATA_W    = SCHED_DATA_W,
    parameter  int WB_NUM    = 4,
    parameter  int PAYLOAD_W = SCHED_PAYLOAD_W,
    localparam int TAG_W     = $clog2(PREG_NUM)
) (
    input  logic                                 clk,
    input  logic                                 a_rst_n,
    input  logic                                 flush_i,
    input  logic [LANE_NUM-1:0]                  issue_valid_i,
    output logic [LANE_NUM-1:0]                  issue_ready_o,
    input  logic [LANE_NUM-1:0][TAG_W-1:0]       issue_psrc0_i,
    input  logic [LANE_NUM-1:0][TAG_W-1:0]       issue_psrc1_i,
    input  logic [LANE_NUM-1:0]                  issue_psrc0_valid_i,
    input  logic [LANE_NUM-1:0]                  issue_psrc1_valid_i,
    input  logic [LANE_NUM-1:0][PAYLOAD_W-1:0]   issue_payload_i,
    output logic [2*LANE_NUM-1:0][TAG_W-1:0]     prf_raddr_o,
    input  logic [2*LANE_NUM-1:0][DATA_W-1:0]    prf_rdata_i,
    input  logic [WB_NUM-1:0]                    wb_valid_i,
    input  logic [WB_NUM-1:0][TAG_W-1:0]         wb_pdest_i,
    input  logic [WB_NUM-1:0][DATA_W-1:0]        wb_data_i,
    output logic [LANE_NUM-1:0]                  exe_valid_o,
    input  logic [LANE_NUM-1:0]                  exe_ready_i,
    output logic [LANE_NUM-1:0][DATA_W-1:0]      exe_src0_o,
    output logic [LANE_NUM-1:0][DATA_W-1:0]      exe_src1_o,
    output logic [LANE_NUM-1:0][PAYLOAD_W-1:0]   exe_payload_o
);

    localparam int ENTRY_W = 2 * DATA_W + PAYLOAD_W;

    // Zero tag and unused sources read as zero; otherwise the lowest-index writeback hit wins.
    function automatic logic [DATA_W-1:0] resolve(input logic [TAG_W-1:0]  tag,
                                                  input logic              used,
                                                  input logic [DATA_W-1:0] rdata);
        logic [DATA_W-1:0] r;
        r = rdata;
`ifdef REG_READ_BYPASS_EN
        for (int w = WB_NUM - 1; w >= 0; w--) begin
            if (wb_valid_i[w] && (wb_pdest_i[w] == tag)) begin
                r = wb_data_i[w];
            end
        end
`endif
        if ((tag == '0) || !used) begin
            r = '0;
        end
        return r;
    endfunction

`ifndef REG_READ_BYPASS_EN
    logic wb_unused;
    assign wb_unused = ^{wb_valid_i, wb_pdest_i, wb_data_i};
`endif

    for (genvar l = 0; l < LANE_NUM; l++) begin : g_lane
        logic [DATA_W-1:0]  src0_res;
        logic [DATA_W-1:0]  src1_res;
        logic [ENTRY_W-1:0] in_entry;
        logic [ENTRY_W-1:0] out_entry;

        assign prf_raddr_o[2*l]   = issue_psrc0_i[l];
        assign prf_raddr_o[2*l+1] = issue_psrc1_i[l];

        assign src0_res = resolve(issue_psrc0_i[l], issue_psrc0_valid_i[l], prf_rdata_i[2*l]);
        assign src1_res = resolve(issue_psrc1_i[l], issue_psrc1_valid_i[l], prf_rdata_i[2*l+1]);
        assign in_entry = {src0_res, src1_res, issue_payload_i[l]};

        reg_read_skid_buf #(
            .W (ENTRY_W)
        ) u_buf (
            .clk         (clk),
            .a_rst_n     (a_rst_n),
            .flush_i     (flush_i),
            .in_valid_i  (issue_valid_i[l]),
            .in_ready_o  (issue_ready_o[l]),
            .in_data_i   (in_entry),
            .out_valid_o (exe_valid_o[l]),
            .out_ready_i (exe_ready_i[l]),
            .out_data_o  (out_entry)
        );

        assign exe_src0_o[l]    = out_entry[ENTRY_W-1 -: DATA_W];
        assign exe_src1_o[l]    = out_entry[PAYLOAD_W +: DATA_W];
        assign exe_payload_o[l] = out_entry[PAYLOAD_W-1:0];
    end

endmodule

// File: tb/tb_reg_read_stage.sv
// Self-checking bench for reg_read_stage: directed scenarios plus a per-lane scoreboard.
// Expected operands follow REG_READ_BYPASS_EN when the bench is built with it.
module tb_reg_read_stage;

  localparam int LN = 2;
  localparam int PN = 64;
  localparam int TW = 6;
  localparam int DW = 32;
  localparam int WN = 4;
  localparam int PW = 64;
  localparam int EW = 2 * DW + PW;

  logic                     clk = 1'b0;
  logic                     a_rst_n;
  logic                     flush;
  logic [LN-1:0]            issue_valid;
  logic [LN-1:0]            issue_ready;
  logic [LN-1:0][TW-1:0]    psrc0, psrc1;
  logic [LN-1:0]            psrc0_valid, psrc1_valid;
  logic [LN-1:0][PW-1:0]    issue_payload;
  logic [2*LN-1:0][TW-1:0]  prf_raddr;
  logic [2*LN-1:0][DW-1:0]  prf_rdata;
  logic [WN-1:0]            wb_valid;
  logic [WN-1:0][TW-1:0]    wb_pdest;
  logic [WN-1:0][DW-1:0]    wb_data;
  logic [LN-1:0]            exe_valid;
  logic [LN-1:0]            exe_ready;
  logic [LN-1:0][DW-1:0]    exe_src0, exe_src1;
  logic [LN-1:0][PW-1:0]    exe_payload;

  logic [DW-1:0]            prf [PN];
  logic [EW-1:0]            exp_q0[$];
  logic [EW-1:0]            exp_q1[$];
  logic [31:0]              seq = 0;
  int                       checks = 0;
  int                       errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  reg_read_stage dut (
    .clk                 (clk),
    .a_rst_n             (a_rst_n),
    .flush_i             (flush),
    .issue_valid_i       (issue_valid),
    .issue_ready_o       (issue_ready),
    .issue_psrc0_i       (psrc0),
    .issue_psrc1_i       (psrc1),
    .issue_psrc0_valid_i (psrc0_valid),
    .issue_psrc1_valid_i (psrc1_valid),
    .issue_payload_i     (issue_payload),
    .prf_raddr_o         (prf_raddr),
    .prf_rdata_i         (prf_rdata),
    .wb_valid_i          (wb_valid),
    .wb_pdest_i          (wb_pdest),
    .wb_data_i           (wb_data),
    .exe_valid_o         (exe_valid),
    .exe_ready_i         (exe_ready),
    .exe_src0_o          (exe_src0),
    .exe_src1_o          (exe_src1),
    .exe_payload_o       (exe_payload)
  );

  for (genvar i = 0; i < 2 * LN; i++) begin : g_prf
    assign prf_rdata[i] = prf[prf_raddr[i]];
  end

  function automatic logic [DW-1:0] model_operand(input logic [TW-1:0] tag, input logic used);
    if (tag == '0 || !used) return '0;
`ifdef REG_READ_BYPASS_EN
    for (int w = 0; w < WN; w++) begin
      if (wb_valid[w] && wb_pdest[w] == tag) return wb_data[w];
    end
`endif
    return prf[tag];
  endfunction

  // scoreboard: push on accept, pop on exe transfer, both sampled on the falling edge
  always @(negedge clk) begin : sb
    logic [EW-1:0] got, want;
    if (!a_rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      for (int l = 0; l < LN; l++) begin
        if (exe_valid[l] && exe_ready[l]) begin
          got = {exe_src0[l], exe_src1[l], exe_payload[l]};
          checks++;
          if ((l == 0 && exp_q0.size() == 0) || (l == 1 && exp_q1.size() == 0)) begin
            errors++;
            $display("FAIL sb_unexpected lane %0d got %h required none", l, got);
          end else begin
            if (l == 0) want = exp_q0.pop_front();
            else        want = exp_q1.pop_front();
            if (got !== want) begin
              errors++;
              $display("FAIL sb_data lane %0d got %h required %h", l, got, want);
            end
          end
        end
      end
      if (flush) begin
        exp_q0.delete();
        exp_q1.delete();
      end else begin
        for (int l = 0; l < LN; l++) begin
          if (issue_valid[l] && issue_ready[l]) begin
            want = {model_operand(psrc0[l], psrc0_valid[l]),
                    model_operand(psrc1[l], psrc1_valid[l]), issue_payload[l]};
            if (l == 0) exp_q0.push_back(want);
            else        exp_q1.push_back(want);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid   = '0;
    flush         = 1'b0;
    wb_valid      = '0;
    wb_pdest      = '0;
    wb_data       = '0;
    psrc0         = '0;
    psrc1         = '0;
    psrc0_valid   = '0;
    psrc1_valid   = '0;
    issue_payload = '0;
  endtask

  task automatic set_uop(input int l, input logic [TW-1:0] s0, input logic v0,
                         input logic [TW-1:0] s1, input logic v1);
    issue_valid[l]   = 1'b1;
    psrc0[l]         = s0;
    psrc0_valid[l]   = v0;
    psrc1[l]         = s1;
    psrc1_valid[l]   = v1;
    issue_payload[l] = {32'hA5A5_0000 | 32'(l), seq};
    seq++;
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0;
    idle_inputs();
    exe_ready = '1;
    step();
    step();
    checks++;
    if (exe_valid !== '0) begin errors++; $display("FAIL rst_exe_valid got %b required 00", exe_valid); end
    checks++;
    if (issue_ready !== '1) begin errors++; $display("FAIL rst_issue_ready got %b required 11", issue_ready); end
    checks++;
    if (exe_src0 !== '0 || exe_src1 !== '0 || exe_payload !== '0) begin
      errors++;
      $display("FAIL rst_data got %h %h %h required 0", exe_src0, exe_src1, exe_payload);
    end
    a_rst_n = 1'b1;
    step();
    checks++;
    if (exe_valid !== '0 || issue_ready !== '1) begin
      errors++;
      $display("FAIL post_rst got valid %b ready %b required 00 11", exe_valid, issue_ready);
    end
  endtask

  task automatic test_prf_read();
    exe_ready = '1;
    prf[5] = 32'h11;
    set_uop(0, 6'd5, 1'b1, 6'd0, 1'b0);
    #1;
    checks++;
    if (prf_raddr[0] !== 6'd5) begin errors++; $display("FAIL prf_raddr got %0d required 5", prf_raddr[0]); end
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (exe_valid[0] !== 1'b1 || exe_src0[0] !== 32'h11) begin
      errors++;
      $display("FAIL prf_read got valid %b src0 %h required 1 00000011", exe_valid[0], exe_src0[0]);
    end
    step();
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want;
`ifdef REG_READ_BYPASS_EN
    want = 32'hAB;
`else
    want = 32'h77;
`endif
    exe_ready = '1;
    prf[7] = 32'h77;
    prf[3] = 32'h33;
    wb_valid    = 4'b1100;
    wb_pdest[2] = 6'd7;
    wb_data[2]  = 32'hAB;
    wb_pdest[3] = 6'd7;
    wb_data[3]  = 32'hCD;
    set_uop(1, 6'd3, 1'b1, 6'd7, 1'b1);
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (exe_valid[1] !== 1'b1 || exe_src1[1] !== want) begin
      errors++;
      $display("FAIL bypass_src1 got valid %b src1 %h required 1 %h", exe_valid[1], exe_src1[1], want);
    end
    checks++;
    if (exe_src0[1] !== 32'h33) begin errors++; $display("FAIL bypass_src0 got %h required 00000033", exe_src0[1]); end
    step();
  endtask

  task automatic test_zero_operands();
    exe_ready = '1;
    prf[0] = 32'hDEAD;
    prf[9] = 32'h99;
    wb_valid[0] = 1'b1;
    wb_pdest[0] = 6'd9;
    wb_data[0]  = 32'h5555;
    set_uop(0, 6'd0, 1'b1, 6'd9, 1'b0);
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (exe_valid[0] !== 1'b1 || exe_src0[0] !== '0 || exe_src1[0] !== '0) begin
      errors++;
      $display("FAIL zero_ops got valid %b %h %h required 1 0 0", exe_valid[0], exe_src0[0], exe_src1[0]);
    end
    step();
  endtask

  task automatic test_stall();
    exe_ready = 2'b10;
    prf[10] = 32'hA0;
    prf[11] = 32'hB0;
    set_uop(0, 6'd10, 1'b1, 6'd0, 1'b0);
    step();
    checks++;
    if (issue_ready[0] !== 1'b1) begin errors++; $display("FAIL stall_ready_a got %b required 1", issue_ready[0]); end
    set_uop(0, 6'd11, 1'b1, 6'd0, 1'b0);
    step();
    idle_inputs();
    checks++;
    if (issue_ready[0] !== 1'b0) begin errors++; $display("FAIL stall_ready_b got %b required 0", issue_ready[0]); end
    prf[10] = 32'h0;
    prf[11] = 32'h0;
    step();
    checks++;
    if (exe_valid[0] !== 1'b1 || exe_src0[0] !== 32'hA0 || issue_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold got valid %b src0 %h ready %b required 1 a0 0", exe_valid[0], exe_src0[0], issue_ready[0]);
    end
    exe_ready = '1;
    @(negedge clk);
    checks++;
    if (exe_src0[0] !== 32'hA0) begin errors++; $display("FAIL release_a got %h required a0", exe_src0[0]); end
    step();
    @(negedge clk);
    checks++;
    if (exe_valid[0] !== 1'b1 || exe_src0[0] !== 32'hB0) begin
      errors++;
      $display("FAIL release_b got valid %b src0 %h required 1 b0", exe_valid[0], exe_src0[0]);
    end
    step();
    @(negedge clk);
    checks++;
    if (exe_valid[0] !== 1'b0 || issue_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL release_empty got valid %b ready %b required 0 1", exe_valid[0], issue_ready[0]);
    end
    step();
  endtask

  task automatic test_flush();
    exe_ready = 2'b10;
    set_uop(0, 6'd1, 1'b1, 6'd2, 1'b1);
    step();
    set_uop(0, 6'd3, 1'b1, 6'd4, 1'b1);
    step();
    set_uop(0, 6'd5, 1'b1, 6'd6, 1'b1);
    set_uop(1, 6'd7, 1'b1, 6'd8, 1'b1);
    flush = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (exe_valid !== '0 || issue_ready !== '1) begin
      errors++;
      $display("FAIL flush got valid %b ready %b required 00 11", exe_valid, issue_ready);
    end
    exe_ready = '1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (exe_valid !== '0) begin errors++; $display("FAIL flush_ghost got valid %b required 00", exe_valid); end
      step();
    end
  endtask

  task automatic test_reset_mid_stall();
    exe_ready = 2'b10;
    set_uop(0, 6'd1, 1'b1, 6'd0, 1'b0);
    step();
    set_uop(0, 6'd2, 1'b1, 6'd0, 1'b0);
    step();
    idle_inputs();
    #2;
    a_rst_n = 1'b0;
    #1;
    checks++;
    if (exe_valid !== '0 || issue_ready !== '1 || exe_src0[0] !== '0 || exe_payload[0] !== '0) begin
      errors++;
      $display("FAIL async_rst got valid %b ready %b src0 %h pl %h required 00 11 0 0",
               exe_valid, issue_ready, exe_src0[0], exe_payload[0]);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    a_rst_n = 1'b1;
    exe_ready = '1;
    prf[12] = 32'hC12;
    prf[13] = 32'hC13;
    set_uop(0, 6'd12, 1'b1, 6'd13, 1'b1);
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (exe_valid[0] !== 1'b1 || exe_src0[0] !== 32'hC12 || exe_src1[0] !== 32'hC13) begin
      errors++;
      $display("FAIL post_rst_flow got valid %b %h %h required 1 c12 c13", exe_valid[0], exe_src0[0], exe_src1[0]);
    end
    step();
  endtask

  task automatic drive_random_uops();
    for (int w = 0; w < WN; w++) begin
      wb_valid[w] = 1'($urandom_range(0, 1));
      wb_pdest[w] = 6'($urandom_range(0, 15));
      wb_data[w]  = $urandom;
    end
    for (int l = 0; l < LN; l++) begin
      issue_valid[l] = 1'b0;
      if ($urandom_range(0, 3) != 0) begin
        set_uop(l, 6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
    end
  endtask

  task automatic test_back_to_back();
    int bad_ready = 0;
    int bad_valid = 0;
    int cyc = 0;
    for (int i = 0; i < PN; i++) prf[i] = $urandom;
    exe_ready = '1;
    for (int c = 0; c < 40; c++) begin
      if (issue_ready !== '1) bad_ready++;
      if (c > 0 && exe_valid !== '1) bad_valid++;
      for (int w = 0; w < WN; w++) begin
        wb_valid[w] = 1'($urandom_range(0, 1));
        wb_pdest[w] = 6'($urandom_range(0, 15));
        wb_data[w]  = $urandom;
      end
      for (int l = 0; l < LN; l++) begin
        set_uop(l, 6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      step();
    end
    checks++;
    if (bad_ready != 0) begin errors++; $display("FAIL b2b_ready got %0d stalls required 0", bad_ready); end
    checks++;
    if (bad_valid != 0) begin errors++; $display("FAIL b2b_valid got %0d bubbles required 0", bad_valid); end
    for (int c = 0; c < 80; c++) begin
      exe_ready = 2'($urandom_range(0, 3));
      drive_random_uops();
      step();
    end
    idle_inputs();
    exe_ready = '1;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && cyc < 20) begin
      step();
      cyc++;
    end
    step();
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0 || exe_valid !== '0) begin
      errors++;
      $display("FAIL drain got q0 %0d q1 %0d valid %b required 0 0 00", exp_q0.size(), exp_q1.size(), exe_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < PN; i++) prf[i] = 32'h1000 + i;
    test_reset();
    test_prf_read();
    test_bypass();
    test_zero_operands();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
